// File: rtl/vlane_mem_if.sv
// Per-lane memory interface: queues issue-stage loads/stores in order and drives a
// single valid/ready memory channel. Optional response timeout: VLANE_MEM_TIMEOUT_EN.
module vlane_mem_if #(
    parameter int LANES_DATA_WIDTH = 64,
    parameter int ADDR_W           = 32,
    parameter int QDEPTH           = 4,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wait_load_signal,
    input  logic [4:0]                  load_destination,
    input  logic                        store_req,
    input  logic [LANES_DATA_WIDTH-1:0] wrdata,
    input  logic [LANES_DATA_WIDTH-1:0] indexed,
    input  logic                        indexed_op,
    input  logic [ADDR_W-1:0]           base_addr,
    output logic                        busy,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic                        mem_req_we,
    output logic [ADDR_W-1:0]           mem_req_addr,
    output logic [LANES_DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                        mem_resp_valid,
    input  logic [LANES_DATA_WIDTH-1:0] mem_resp_rdata,
    output logic                        read_done,
    output logic [4:0]                  load_data_destination,
    output logic [LANES_DATA_WIDTH-1:0] data_from_load,
    output logic                        store_done,
    output logic                        protocol_err,
    output logic                        timeout_err
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic                        we;
        logic [ADDR_W-1:0]           addr;
        logic [LANES_DATA_WIDTH-1:0] wdata;
        logic [4:0]                  dest;
    } req_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RESP
    } state_t;

    state_t           state;
    req_t             q_mem [QDEPTH];
    req_t             cur;
    req_t             new_entry;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             any_strobe;

    generate
        if (LANES_DATA_WIDTH > ADDR_W) begin : g_idx_hi
            logic unused_idx_hi;
            assign unused_idx_hi = ^indexed[LANES_DATA_WIDTH-1:ADDR_W];
        end
    endgenerate

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        new_entry       = '0;
        any_strobe      = wait_load_signal | store_req;
        full            = (count == CNT_W'(QDEPTH));
        empty           = (count == '0);
        push            = any_strobe & ~full;
        pop             = (state == IDLE) & ~empty;
        // A load wins over a simultaneous store; loads carry zero write data.
        new_entry.we    = ~wait_load_signal;
        new_entry.addr  = base_addr + (indexed_op ? indexed[ADDR_W-1:0] : '0);
        new_entry.wdata = wait_load_signal ? '0 : wrdata;
        new_entry.dest  = wait_load_signal ? load_destination : 5'd0;
    end

    assign busy          = full;
    assign mem_req_we    = cur.we;
    assign mem_req_addr  = cur.addr;
    assign mem_req_wdata = cur.wdata;

    // NOTE: the queue storage has no reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef VLANE_MEM_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TMO_W-1:0] tmo_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                 <= IDLE;
            cur                   <= '0;
            mem_req_valid         <= 1'b0;
            read_done             <= 1'b0;
            load_data_destination <= '0;
            data_from_load        <= '0;
            store_done            <= 1'b0;
            protocol_err          <= 1'b0;
`ifdef VLANE_MEM_TIMEOUT_EN
            timeout_err           <= 1'b0;
            tmo_cnt               <= '0;
`endif
        end else begin
            read_done             <= 1'b0;
            load_data_destination <= '0;
            data_from_load        <= '0;
            store_done            <= 1'b0;

            if ((any_strobe && full) || (wait_load_signal && store_req)) begin
                protocol_err <= 1'b1;
            end
            if (mem_resp_valid && (state != WAIT_RESP)) begin
                protocol_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (!empty) begin
                        cur           <= q_mem[rd_ptr];
                        mem_req_valid <= 1'b1;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        if (cur.we) begin
                            store_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            state      <= WAIT_RESP;
`ifdef VLANE_MEM_TIMEOUT_EN
                            tmo_cnt    <= '0;
`endif
                        end
                    end
                end
                WAIT_RESP: begin
                    if (mem_resp_valid) begin
                        read_done             <= 1'b1;
                        load_data_destination <= cur.dest;
                        data_from_load        <= mem_resp_rdata;
                        state                 <= IDLE;
                    end
`ifdef VLANE_MEM_TIMEOUT_EN
                    // Give up on the response: retire the load with zero data.
                    else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES)) begin
                        read_done             <= 1'b1;
                        load_data_destination <= cur.dest;
                        data_from_load        <= '0;
                        timeout_err           <= 1'b1;
                        state                 <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                default: begin
                    mem_req_valid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule
